// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-coding helpers and defaults for the dual-clock FIFO controllers.
// The functions are width-agnostic: callers pass zero-extended pointers and truncate the result.
package fifo_pkg;
  localparam int FIFO_ADDR_BITS = 6;
  localparam int FIFO_SYNC_STAGES = 2;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: N-stage, W-bit flop synchroniser for a Gray pointer crossing clock domains.
module fifo_ptr_sync #(
  parameter int W = 7,
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [N-1:0][W-1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[N-2:0], d_i};
  end
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side pointer, full/fill/overflow flags and Gray pointer export of the dual-clock FIFO.
// Define FIFO_ALMOST_FULL_EN to build the registered almost-full flag; otherwise o_almost_full is 0.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_BITS          = FIFO_ADDR_BITS,
  parameter int SYNC_STAGES        = FIFO_SYNC_STAGES,
  parameter int ALMOST_FULL_THRESH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS:0]   i_rd_ptr_gray,
  output logic                 o_wr_en,
  output logic [ADDR_BITS-1:0] o_wr_addr,
  output logic [ADDR_BITS:0]   o_wr_ptr_gray,
  output logic                 o_full,
  output logic                 o_almost_full,
  output logic [ADDR_BITS:0]   o_fill_level,
  output logic                 o_overflow
);
  localparam int PW = ADDR_BITS + 1;
  localparam int DEPTH = 2 ** ADDR_BITS;
  logic [PW-1:0] wbin_q, wbin_d, gray_q, gray_d, fill_q, fill_d, rq_gray, rq_bin;
  logic full_q, full_d, ovf_q, accept;
  fifo_ptr_sync #(.W(PW), .N(SYNC_STAGES)) u_rd_sync (
    .clk_i (i_clk),
    .rst_ni(i_reset_n),
    .d_i   (i_rd_ptr_gray),
    .q_o   (rq_gray)
  );
  // Reset gates the strobe so no RAM write can slip out while pointers are held at 0.
  always_comb begin
    accept = i_wr_en && !full_q && i_reset_n;
    wbin_d = wbin_q + PW'(accept);
    gray_d = PW'(bin2gray(32'(wbin_d)));
    rq_bin = PW'(gray2bin(32'(rq_gray)));
    fill_d = wbin_d - rq_bin;
    full_d = gray_d == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]};
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wbin_q <= '0;
      gray_q <= '0;
      fill_q <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      gray_q <= gray_d;
      fill_q <= fill_d;
      full_q <= full_d;
      ovf_q  <= i_wr_en && full_q;
    end
  end
`ifdef FIFO_ALMOST_FULL_EN
  logic [PW:0] free_d;
  logic af_q, af_d;
  always_comb begin
    free_d = (PW+1)'(DEPTH) - {1'b0, fill_d};
    af_d = free_d <= (PW+1)'(ALMOST_FULL_THRESH);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) af_q <= 1'b0;
    else af_q <= af_d;
  end
  assign o_almost_full = af_q;
`else
  // Constant 0 for any legal threshold; the threshold only matters when almost-full is built in.
  assign o_almost_full = (ALMOST_FULL_THRESH < 0) && (DEPTH < 0);
`endif
  assign o_wr_en       = accept;
  assign o_wr_addr     = wbin_q[ADDR_BITS-1:0];
  assign o_wr_ptr_gray = gray_q;
  assign o_fill_level  = fill_q;
  assign o_full        = full_q;
  assign o_overflow    = ovf_q;
endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control for the Ethernet dual-clock FIFO. It sits in the write clock domain directly upstream of the dual-port FIFO RAM. It generates the RAM write address, gates writes against a full condition, and publishes a Gray-coded write pointer to the read domain. It also synchronises the read domain's Gray pointer back in, deriving full, fill level, overflow and, optionally, almost-full.

## Interface
- ADDR_BITS, 6, RAM address width; depth = 2**ADDR_BITS
- SYNC_STAGES, 2, flops in the read-pointer synchroniser (legal ≥ 2)
- ALMOST_FULL_THRESH, 4, almost-full asserted when free slots ≤ this value
- i_clk  in  1  write-domain clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_wr_en  in  1  write request from producer
- i_rd_ptr_gray  in  ADDR_BITS+1  read pointer, Gray, asynchronous to i_clk
- o_wr_en  out  1  qualified write strobe to RAM (i_wr_en && !o_full)
- o_wr_addr  out  ADDR_BITS  RAM write address
- o_wr_ptr_gray  out  ADDR_BITS+1  registered Gray write pointer to read domain
- o_full  out  1  FIFO full; writes are dropped
- o_almost_full  out  1  see Configuration
- o_fill_level  out  ADDR_BITS+1  pessimistic occupancy, 0..depth
- o_overflow  out  1  one-cycle pulse on a dropped write

## Operation
- Internal binary pointer wbin[ADDR_BITS:0]; o_wr_addr = wbin[ADDR_BITS-1:0]; extra MSB is the wrap bit.
- Accepted write: o_wr_en = i_wr_en && !o_full (combinational). On accept, wbin += 1, wrapping modulo 2**(ADDR_BITS+1).
- o_wr_ptr_gray: register holding wbin_next ^ (wbin_next >> 1). Only one bit changes per increment. Never driven combinationally.
- Read-pointer path:
  - i_rd_ptr_gray passes through SYNC_STAGES flops to give rq_gray.
  - rq_bin is gray-to-binary of rq_gray.
- Full, registered: o_full <= (gray_next == {~rq_gray[MSB:MSB-1], rq_gray[MSB-2:0]}).
- Fill: o_fill_level <= (wbin_next − rq_bin) mod 2**(ADDR_BITS+1), an unsigned ADDR_BITS+1 result.
- Overflow: o_overflow <= i_wr_en && o_full. Write data is not forwarded to RAM.
- No state machine beyond pointer, synchroniser, and flag registers.

## Timing
- Reset (async assert, sync to i_clk edge on deassert): wbin, o_wr_ptr_gray, synchroniser flops and o_fill_level are 0; o_full, o_almost_full and o_overflow are 0; o_wr_addr is 0.
- Write accepted at edge N: RAM captures at o_wr_addr during cycle N; o_wr_addr, o_wr_ptr_gray and o_fill_level update at edge N.
- Full is set at the same edge that accepts the depth-th unread write. The next i_wr_en is blocked, with zero cycles of slack.
- Read-pointer change reaches o_full/o_fill_level SYNC_STAGES+1 edges after it is stable at the input. Full and fill are therefore pessimistic and never optimistic.
- Write and read-pointer update in the same cycle: both are reflected; a write blocked by a stale full is dropped and flagged.
- Wrap: address 2**ADDR_BITS−1 → 0 with the wrap bit toggled. Full and empty are distinguished solely by the wrap bit.
- Reset mid-operation: pointers return to 0 immediately. The read domain must be reset concurrently; this is the system requirement.

## Configuration
- FIFO_ALMOST_FULL_EN defined:
  - o_almost_full <= (2**ADDR_BITS − fill_next) ≤ ALMOST_FULL_THRESH, registered with o_full.
  - It stays asserted while o_full is set.
- FIFO_ALMOST_FULL_EN undefined: o_almost_full is tied to 0 and the comparator logic is absent. The port is retained so the interface is stable.

## Structure
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised by width
  - default depth and sync-stage constants
  - reused by the matching read-side controller
- One sub-module: fifo_ptr_sync, an N-stage, width-W flop synchroniser with async active-low reset. It is instantiated once here and once in the read controller.

## Test plan
- Reset with i_wr_en=1 held → all outputs 0 during reset, no o_wr_en pulse. First accept after release gives o_wr_addr=0→1 and o_wr_ptr_gray=0→1.
- 64 consecutive writes, i_rd_ptr_gray=0 → o_full=1 at the 64th edge, o_fill_level=64, o_wr_addr=0. The 65th request produces o_wr_en=0 and an o_overflow pulse.
- From full, change i_rd_ptr_gray to gray(1) → o_full=0 exactly SYNC_STAGES+1 edges later, with o_fill_level=63.
- With FIFO_ALMOST_FULL_EN, 60 writes → o_almost_full=1 at the 60th edge, 0 at 59. Without the macro, o_almost_full stays 0 throughout.
- Wrap: stream 200 writes with the read pointer trailing by 10 → o_wr_ptr_gray shows exactly 1 bit change per accept, and the wrap bit toggles at 64 and 128.
- Assert i_reset_n low at a fill of 30 → all outputs 0 asynchronously, without waiting for a clock edge.
